// File: rtl/calc_sequencer.sv
// Program-driven initiator for the accumulator calculator datapath: runs a host-written
// instruction store, issues (IN, OP) pairs, checks errors and captures results.
module calc_sequencer #(
  parameter int DEPTH = 32,
  parameter int NRES  = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PW_EN,
  input  logic [AW-1:0] PW_ADDR,
  input  logic [21:0]   PW_DATA,
  input  logic          START,
  output logic [15:0]   DP_IN,
  output logic [3:0]    DP_OP,
  input  logic [31:0]   DP_OUT,
  input  logic [1:0]    DP_ERR,
  input  logic [1:0]    RES_SEL,
  output logic [31:0]   RES_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAULT,
  output logic [1:0]    FAULT_CODE,
  output logic [AW-1:0] FAULT_PC
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FETCH, S_ISSUE, S_CHECK, S_STORE, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_IMM = 2'b00, K_REG = 2'b01, K_STORE = 2'b10, K_HALT = 2'b11
  } kind_t;

  state_t        r_state;
  state_t        w_next;
  logic [21:0]   r_mem [DEPTH];
  logic [31:0]   r_res [NRES];
  logic [21:0]   r_ir;
  logic [AW-1:0] r_pc;
  logic          r_fault;
  logic [1:0]    r_fault_code;
  logic [AW-1:0] r_fault_pc;
  logic [21:0]   w_fetch;
  logic          w_last;
  kind_t         w_fetch_kind;
  kind_t         w_ir_kind;

  assign w_fetch      = r_mem[r_pc];
  assign w_fetch_kind = kind_t'(w_fetch[21:20]);
  assign w_ir_kind    = kind_t'(r_ir[21:20]);
  assign w_last       = (r_pc == AW'(DEPTH - 1));

  // Store is deliberately left out of reset so a program survives an aborted run.
  always_ff @(posedge CLK) begin
    if (PW_EN && !BUSY) r_mem[PW_ADDR] <= PW_DATA;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START) w_next = S_INIT;
      S_INIT:  w_next = S_FETCH;
      S_FETCH: begin
        case (w_fetch_kind)
          K_HALT:  w_next = S_DONE;
          K_STORE: w_next = S_STORE;
          default: w_next = S_ISSUE;
        endcase
      end
      S_ISSUE: w_next = S_CHECK;
      S_CHECK: w_next = (DP_ERR != 2'b00 || w_last) ? S_DONE : S_FETCH;
      S_STORE: w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    DP_OP = '0;
    DP_IN = '0;
    BUSY  = 1'b1;
    DONE  = 1'b0;
    case (r_state)
      S_IDLE:  BUSY  = 1'b0;
      S_INIT:  DP_OP = '1;
      S_ISSUE: begin
        DP_OP = r_ir[19:16];
        DP_IN = (w_ir_kind == K_REG) ? r_res[r_ir[1:0]][15:0] : r_ir[15:0];
      end
      S_DONE: begin
        DONE = 1'b1;
        BUSY = 1'b0;
      end
      default: ;
    endcase
  end

  // Executing the last store entry without HALT ends the run; PC holds rather than wrapping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pc         <= '0;
      r_ir         <= '0;
      r_fault      <= 1'b0;
      r_fault_code <= '0;
      r_fault_pc   <= '0;
      for (int unsigned i = 0; i < NRES; i++) r_res[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (START) begin
          r_fault <= 1'b0;
          r_pc    <= '0;
        end
        S_FETCH: r_ir <= w_fetch;
        S_CHECK: begin
          if (DP_ERR != 2'b00) begin
            r_fault      <= 1'b1;
            r_fault_code <= DP_ERR;
            r_fault_pc   <= r_pc;
          end else if (!w_last) begin
            r_pc <= r_pc + AW'(1);
          end
        end
        S_STORE: begin
          r_res[r_ir[1:0]] <= DP_OUT;
          if (!w_last) r_pc <= r_pc + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign RES_DATA   = r_res[RES_SEL];
  assign FAULT      = r_fault;
  assign FAULT_CODE = r_fault_code;
  assign FAULT_PC   = r_fault_pc;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural accumulator datapath plus a program-level
// interpreter that predicts ops issued, cycle count, results and faults.
module tb_calc_sequencer;

  localparam int DEPTH = 32;
  localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3, OP_DIV = 4'h4, OP_CLR = 4'hF;
  localparam logic [1:0] K_IMM = 2'b00, K_REG = 2'b01, K_STO = 2'b10, K_HLT = 2'b11;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        PW_EN = 1'b0;
  logic [4:0]  PW_ADDR = '0;
  logic [21:0] PW_DATA = '0;
  logic        START = 1'b0;
  logic [15:0] DP_IN;
  logic [3:0]  DP_OP;
  logic [31:0] DP_OUT;
  logic [1:0]  DP_ERR;
  logic [1:0]  RES_SEL = '0;
  logic [31:0] RES_DATA;
  logic        BUSY, DONE, FAULT;
  logic [1:0]  FAULT_CODE;
  logic [4:0]  FAULT_PC;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  calc_sequencer #(.DEPTH(DEPTH), .NRES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .PW_EN(PW_EN), .PW_ADDR(PW_ADDR), .PW_DATA(PW_DATA),
    .START(START), .DP_IN(DP_IN), .DP_OP(DP_OP), .DP_OUT(DP_OUT), .DP_ERR(DP_ERR),
    .RES_SEL(RES_SEL), .RES_DATA(RES_DATA), .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT),
    .FAULT_CODE(FAULT_CODE), .FAULT_PC(FAULT_PC)
  );

  // Accumulator datapath: registered result, error reported the cycle after the op.
  logic [31:0] acc = '0;
  logic [1:0]  err = '0;
  bit          noise = 1'b0;
  assign DP_OUT = acc;
  assign DP_ERR = err;

  always @(posedge CLK) begin
    err <= 2'b00;
    case (DP_OP)
      4'h0:   if (noise) err <= 2'($urandom_range(0, 3));
      OP_ADD: acc <= acc + {16'h0, DP_IN};
      OP_SUB: acc <= acc - {16'h0, DP_IN};
      OP_MUL: acc <= acc * {16'h0, DP_IN};
      OP_DIV: if (DP_IN == 16'h0) err <= 2'b10; else acc <= acc / {16'h0, DP_IN};
      OP_CLR: acc <= '0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [21:0] w(input logic [1:0] k, input logic [3:0] op, input logic [15:0] arg);
    return {k, op, arg};
  endfunction

  logic [21:0] prog [DEPTH];
  logic [31:0] m_res [4];
  logic [19:0] exp_ops [$];
  logic [19:0] obs_ops [$];
  int          exp_cyc;
  bit          exp_fault;
  logic [1:0]  exp_code;
  logic [4:0]  exp_fpc;

  // Program interpreter: walks the instruction list directly, counting cycle costs.
  task automatic model_run();
    logic [31:0] a;
    logic [21:0] wd;
    logic [15:0] opnd;
    a = '0;
    exp_ops.delete();
    exp_ops.push_back({OP_CLR, 16'h0});
    exp_cyc = 1;
    exp_fault = 1'b0;
    for (int pc = 0; pc < DEPTH; pc++) begin
      wd = prog[pc];
      if (wd[21:20] == K_HLT) begin exp_cyc += 1; break; end
      if (wd[21:20] == K_STO) begin m_res[wd[1:0]] = a; exp_cyc += 2; continue; end
      opnd = (wd[21:20] == K_IMM) ? wd[15:0] : m_res[wd[1:0]][15:0];
      exp_ops.push_back({wd[19:16], opnd});
      exp_cyc += 3;
      case (wd[19:16])
        OP_ADD: a = a + 32'(opnd);
        OP_SUB: a = a - 32'(opnd);
        OP_MUL: a = a * 32'(opnd);
        OP_DIV: if (opnd == 0) begin
          exp_fault = 1'b1; exp_code = 2'b10; exp_fpc = 5'(pc);
        end else a = a / 32'(opnd);
        OP_CLR: a = '0;
        default: ;
      endcase
      if (exp_fault) break;
    end
    exp_cyc += 1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge CLK);
      PW_EN = 1'b1; PW_ADDR = 5'(i); PW_DATA = prog[i];
    end
    @(negedge CLK);
    PW_EN = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < DEPTH; i++) prog[i] = w(K_HLT, 4'h0, 16'h0);
  endtask

  task automatic surface_prog();
    fill_halt();
    prog[0]  = w(K_IMM, OP_CLR, 0);  prog[1]  = w(K_IMM, OP_ADD, 4);  prog[2]  = w(K_IMM, OP_MUL, 5);
    prog[3]  = w(K_STO, 4'h0, 0);
    prog[4]  = w(K_IMM, OP_CLR, 0);  prog[5]  = w(K_IMM, OP_ADD, 10); prog[6]  = w(K_IMM, OP_MUL, 5);
    prog[7]  = w(K_STO, 4'h0, 1);
    prog[8]  = w(K_IMM, OP_CLR, 0);  prog[9]  = w(K_IMM, OP_ADD, 4);  prog[10] = w(K_IMM, OP_MUL, 10);
    prog[11] = w(K_STO, 4'h0, 2);
    prog[12] = w(K_IMM, OP_CLR, 0);  prog[13] = w(K_REG, OP_ADD, 0);  prog[14] = w(K_REG, OP_ADD, 1);
    prog[15] = w(K_REG, OP_ADD, 2);  prog[16] = w(K_IMM, OP_MUL, 2);  prog[17] = w(K_STO, 4'h0, 3);
  endtask

  task automatic read_res(input int r, output logic [31:0] v);
    RES_SEL = 2'(r);
    #1 v = RES_DATA;
  endtask

  task automatic run(input string tag, input bit do_sw, input logic [4:0] sw_addr,
                     input logic [21:0] sw_data, input int inject, output int cyc);
    int n;
    bit got;
    logic [31:0] v;
    @(negedge CLK);
    START = 1'b1;
    if (do_sw) begin
      PW_EN = 1'b1; PW_ADDR = sw_addr; PW_DATA = sw_data; prog[sw_addr] = sw_data;
    end
    model_run();
    obs_ops.delete();
    @(negedge CLK);
    START = 1'b0; PW_EN = 1'b0;
    n = 1; got = 1'b0;
    while (n < 400) begin
      if (DP_OP != 4'h0) obs_ops.push_back({DP_OP, DP_IN});
      if (DONE) begin got = 1'b1; break; end
      check({tag, "_busy"}, 32'(BUSY), 1);
      if (n == inject) begin
        PW_EN = 1'b1; PW_ADDR = '0; PW_DATA = w(K_HLT, 4'h0, 16'h0);
      end
      @(negedge CLK);
      PW_EN = 1'b0;
      n++;
    end
    cyc = n;
    check({tag, "_done_seen"}, 32'(got), 1);
    check({tag, "_cycles"}, n, exp_cyc);
    check({tag, "_busy_at_done"}, 32'(BUSY), 0);
    check({tag, "_nops"}, obs_ops.size(), exp_ops.size());
    for (int i = 0; i < obs_ops.size() && i < exp_ops.size(); i++)
      check($sformatf("%s_op%0d", tag, i), 32'(obs_ops[i]), 32'(exp_ops[i]));
    check({tag, "_fault"}, 32'(FAULT), 32'(exp_fault));
    if (exp_fault) begin
      check({tag, "_fcode"}, 32'(FAULT_CODE), 32'(exp_code));
      check({tag, "_fpc"}, 32'(FAULT_PC), 32'(exp_fpc));
    end
    @(negedge CLK);
    check({tag, "_done_pulse"}, 32'(DONE), 0);
    for (int r = 0; r < 4; r++) begin
      read_res(r, v);
      check($sformatf("%s_res%0d", tag, r), v, m_res[r]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;
    logic [31:0] v;
    for (int r = 0; r < 4; r++) m_res[r] = '0;

    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_dp_op", 32'(DP_OP), 0);
    check("rst_dp_in", 32'(DP_IN), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_fault", 32'(FAULT), 0);
    check("rst_fcode", 32'(FAULT_CODE), 0);
    check("rst_fpc", 32'(FAULT_PC), 0);
    for (int r = 0; r < 4; r++) begin
      read_res(r, v);
      check($sformatf("rst_res%0d", r), v, 0);
    end
    RST_N = 1'b1;

    fill_halt();
    prog[0] = w(K_IMM, OP_SUB, 3);
    load_prog();
    run("t1", 1'b0, '0, '0, 0, cyc);
    check("t1_done_cycle", cyc, 6);

    surface_prog();
    load_prog();
    run("t2", 1'b0, '0, '0, 0, cyc);
    read_res(3, v); check("t2_r3", v, 220);
    read_res(0, v); check("t2_r0", v, 20);
    read_res(1, v); check("t2_r1", v, 50);
    read_res(2, v); check("t2_r2", v, 40);

    fill_halt();
    prog[0] = w(K_IMM, OP_ADD, 7); prog[1] = w(K_IMM, OP_DIV, 0); prog[2] = w(K_IMM, OP_ADD, 1);
    load_prog();
    run("t3", 1'b0, '0, '0, 0, cyc);
    check("t3_fault", 32'(FAULT), 1);
    check("t3_fcode", 32'(FAULT_CODE), 2);
    check("t3_fpc", 32'(FAULT_PC), 1);
    check("t3_nops", obs_ops.size(), 3);

    surface_prog();
    load_prog();
    run("t5a", 1'b0, '0, '0, 8, cyc);
    check("t5_fault_cleared", 32'(FAULT), 0);
    run("t5b", 1'b0, '0, '0, 0, cyc);
    read_res(3, v); check("t5_r3", v, 220);

    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while (DP_OP != OP_MUL && k < 100) begin @(negedge CLK); k++; end
    check("t4_mul_seen", 32'(DP_OP), 32'(OP_MUL));
    RST_N = 1'b0;
    @(negedge CLK);
    check("t4_dp_op", 32'(DP_OP), 0);
    check("t4_busy", 32'(BUSY), 0);
    for (int r = 0; r < 4; r++) begin
      read_res(r, v);
      check($sformatf("t4_res%0d", r), v, 0);
      m_res[r] = '0;
    end
    RST_N = 1'b1;
    run("t4", 1'b0, '0, '0, 0, cyc);
    read_res(3, v); check("t4_r3", v, 220);

    fill_halt();
    prog[0] = w(K_IMM, OP_SUB, 3);
    load_prog();
    run("t7_startwr", 1'b1, 5'd0, w(K_IMM, OP_ADD, 9), 0, cyc);
    check("t7_acc", acc, 9);

    fill_halt();
    prog[0] = w(K_STO, 4'h0, 2);
    load_prog();
    run("t8_store0", 1'b0, '0, '0, 0, cyc);
    read_res(2, v); check("t8_r2", v, 0);

    for (int i = 0; i < DEPTH; i++) prog[i] = w(K_IMM, OP_ADD, 1);
    load_prog();
    run("t6", 1'b0, '0, '0, 0, cyc);
    check("t6_dp_out", DP_OUT, 32);
    check("t6_fpc_nowrap", cyc, 1 + 3 * DEPTH + 1);

    noise = 1'b1;
    for (int t = 0; t < 25; t++) begin
      int len;
      logic [3:0] ops [5];
      ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_MUL; ops[3] = OP_DIV; ops[4] = OP_CLR;
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        logic [1:0] kd;
        kd = 2'($urandom_range(0, 2));
        if (i >= len) prog[i] = w(K_HLT, 4'h0, 16'($urandom));
        else if (kd == K_IMM) prog[i] = w(K_IMM, ops[$urandom_range(0, 4)], 16'($urandom_range(0, 9)));
        else if (kd == K_REG) prog[i] = w(K_REG, ops[$urandom_range(0, 4)], 16'($urandom_range(0, 3)));
        else prog[i] = w(K_STO, 4'h0, 16'($urandom_range(0, 3)));
      end
      load_prog();
      run($sformatf("rnd%0d", t), 1'b0, '0, '0, 0, cyc);
    end
    noise = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
